// File: rtl/nr_div_pkg.sv
// Shared definitions for the non-restoring divider: controller states,
// default operand width and iteration-counter width.
package nr_div_pkg;

   localparam int DEF_WIDTH = 8;
   // Wide enough to count iterations for any WIDTH up to 255.
   localparam int CNT_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      ITER,
      FIX,
      OUT_Q,
      OUT_R
   } state_t;

endpackage

// File: rtl/nr_div_step.sv
// One radix-2 non-restoring iteration: shift {A,quotient} left, then add or
// subtract the divisor depending on the sign of the old partial remainder.
module nr_div_step #(
   parameter int WIDTH = nr_div_pkg::DEF_WIDTH
) (
   input  logic [WIDTH:0]   a_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   a_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0] a_shift;
   logic [WIDTH:0] m_ext;

   assign a_shift = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
   assign m_ext   = {1'b0, m};

   // The sign of the partial remainder before the shift selects the operation.
   assign a_out = a_in[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
   assign q_out = {q_in[WIDTH-2:0], ~a_out[WIDTH]};

endmodule

// File: rtl/nr_div.sv
// Sequential unsigned non-restoring divider with fixed WIDTH+3 cycle latency;
// presents the quotient then the remainder on outbus, each qualified by valid.
module nr_div
   import nr_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   input  logic [WIDTH-1:0] M,
   input  logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] outbus,
   output logic             valid,
   output logic             dz
);

   state_t             state, next_state;
   logic [WIDTH:0]     a_reg, a_step;
   logic [WIDTH-1:0]   q_reg, q_step, m_reg;
   logic [CNT_W-1:0]   cnt;

   nr_div_step #(.WIDTH(WIDTH)) u_step (
      .a_in  (a_reg),
      .q_in  (q_reg),
      .m     (m_reg),
      .a_out (a_step),
      .q_out (q_step)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = ITER;
         ITER:    if (cnt == CNT_W'(WIDTH - 1)) next_state = FIX;
         FIX:     next_state = OUT_Q;
         OUT_Q:   next_state = OUT_R;
         OUT_R:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered so they change only on clock edges, except reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         a_reg  <= '0;
         q_reg  <= '0;
         m_reg  <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         valid  <= 1'b0;
         dz     <= 1'b0;
         outbus <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  m_reg <= M;
                  q_reg <= Q;
                  a_reg <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ITER: begin
               a_reg <= a_step;
               q_reg <= q_step;
               cnt   <= cnt + CNT_W'(1);
            end
            FIX: begin
               if (a_reg[WIDTH]) a_reg <= a_reg + {1'b0, m_reg};
               outbus <= q_reg;
               valid  <= 1'b1;
               dz     <= (m_reg == '0);
            end
            OUT_Q: begin
               outbus <= a_reg[WIDTH-1:0];
            end
            OUT_R: begin
               outbus <= '0;
               valid  <= 1'b0;
               dz     <= 1'b0;
               busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nr_div.sv
// Self-checking bench for nr_div: directed and random divisions against
// integer / and %, plus start-ignore, mid-operation reset and back-to-back runs.
module tb_nr_div;

   logic       clk;
   logic       reset;
   logic       start;
   logic       busy;
   logic [7:0] M;
   logic [7:0] Q;
   logic [7:0] outbus;
   logic       valid;
   logic       dz;

   int checks = 0;
   int errors = 0;

   nr_div #(.WIDTH(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .busy   (busy),
      .M      (M),
      .Q      (Q),
      .outbus (outbus),
      .valid  (valid),
      .dz     (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive operands and start at a falling edge; returns at the falling edge after E0.
   task automatic launch(input logic [7:0] q, input logic [7:0] m, input bit hold);
      @(negedge clk);
      Q     = q;
      M     = m;
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Called at the falling edge after E0 (c=0); walks cycles c=0..11 checking
   // busy/valid timing and the result words against plain integer division.
   task automatic run_and_check_op(input logic [7:0] q, input logic [7:0] m,
                                   input bit disturb, input string tag);
      logic [7:0] exp_q, exp_r;
      logic       exp_dz, exp_busy, exp_valid;
      exp_dz = (m == 8'h00);
      exp_q  = exp_dz ? 8'hFF : q / m;
      exp_r  = exp_dz ? q : q % m;
      for (int c = 0; c <= 11; c++) begin
         if (disturb && c == 3) begin
            M     = 8'h03;
            Q     = 8'h99;
            start = 1'b1;
         end
         if (disturb && c == 4) start = 1'b0;
         exp_busy  = (c <= 10);
         exp_valid = (c == 9 || c == 10);
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy, exp_busy);
         end
         checks++;
         if (valid !== exp_valid) begin
            errors++;
            $display("FAIL %s valid c=%0d got %b exp %b", tag, c, valid, exp_valid);
         end
         if (c == 9) begin
            checks++;
            if (outbus !== exp_q) begin
               errors++;
               $display("FAIL %s quotient got %h exp %h (q=%h m=%h)", tag, outbus, exp_q, q, m);
            end
         end
         if (c == 10) begin
            checks++;
            if (outbus !== exp_r) begin
               errors++;
               $display("FAIL %s remainder got %h exp %h (q=%h m=%h)", tag, outbus, exp_r, q, m);
            end
         end
         if (c == 11) begin
            checks++;
            if (outbus !== 8'h00) begin
               errors++;
               $display("FAIL %s outbus_idle got %h exp 00", tag, outbus);
            end
         end
         if (c >= 9) begin
            checks++;
            if (dz !== (exp_dz && c != 11)) begin
               errors++;
               $display("FAIL %s dz c=%0d got %b exp %b", tag, c, dz, exp_dz && c != 11);
            end
         end
         if (c < 11) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start = 1'b0;
      M     = 8'h00;
      Q     = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, valid, dz, outbus} !== 11'h000) begin
         errors++;
         $display("FAIL reset_state got busy=%b valid=%b dz=%b outbus=%h exp all 0",
                  busy, valid, dz, outbus);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed;
      launch(8'h11, 8'h03, 1'b0); run_and_check_op(8'h11, 8'h03, 1'b0, "dir_11_03");
      launch(8'hFF, 8'h01, 1'b0); run_and_check_op(8'hFF, 8'h01, 1'b0, "dir_FF_01");
      launch(8'h05, 8'h07, 1'b0); run_and_check_op(8'h05, 8'h07, 1'b0, "dir_05_07");
      launch(8'hFF, 8'hFF, 1'b0); run_and_check_op(8'hFF, 8'hFF, 1'b0, "dir_FF_FF");
   endtask

   task automatic test_div_zero;
      launch(8'h40, 8'h00, 1'b0); run_and_check_op(8'h40, 8'h00, 1'b0, "dz_40_00");
      launch(8'h00, 8'h00, 1'b0); run_and_check_op(8'h00, 8'h00, 1'b0, "dz_00_00");
   endtask

   task automatic test_random;
      logic [7:0] q, m;
      for (int i = 0; i < 30; i++) begin
         q = 8'($urandom_range(0, 255));
         m = (i % 7 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         launch(q, m, 1'b0);
         run_and_check_op(q, m, 1'b0, "random");
      end
   endtask

   task automatic test_ignore_start;
      launch(8'h64, 8'h0A, 1'b0);
      run_and_check_op(8'h64, 8'h0A, 1'b1, "ignore_start");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_extra_op cycle %0d got busy=%b valid=%b exp 0 0",
                     i, busy, valid);
         end
      end
   endtask

   task automatic test_reset_mid;
      launch(8'hB7, 8'h05, 1'b0);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({busy, valid, dz, outbus} !== 11'h000) begin
         errors++;
         $display("FAIL reset_mid_immediate got busy=%b valid=%b dz=%b outbus=%h exp all 0",
                  busy, valid, dz, outbus);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_result cycle %0d got busy=%b valid=%b exp 0 0",
                     i, busy, valid);
         end
      end
      launch(8'h11, 8'h03, 1'b0);
      run_and_check_op(8'h11, 8'h03, 1'b0, "after_reset");
   endtask

   task automatic test_back_to_back;
      launch(8'hC8, 8'h07, 1'b1);
      run_and_check_op(8'hC8, 8'h07, 1'b0, "b2b_first");
      @(negedge clk);
      start = 1'b0;
      run_and_check_op(8'hC8, 8'h07, 1'b0, "b2b_second");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_third cycle %0d got busy=%b exp 0", i, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_random();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
